// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and widths for the fetch/data byte-memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_dmem_arbiter_word_pack.sv
// Word <-> byte packing for one 4-byte transfer: byte counter, big-endian
// store byte select and the load shift register. The shift register keeps
// only the first three bytes; the fourth is taken straight from mem_rdata so
// the assembled word is ready in the capture cycle.
module arb_word_pack
    import arb_pkg::*;
(
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic              we,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BYTE_W-1:0] mem_rdata,
    output logic [1:0]        cnt,
    output logic              last,
    output logic [BYTE_W-1:0] wbyte,
    output logic [WORD_W-1:0] word
);

    logic [WORD_W-BYTE_W-1:0] shift_q;
    logic                     rd_pend;

    // Byte counter, and shifting of each read byte one cycle after its issue.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 2'd0;
            rd_pend <= 1'b0;
            shift_q <= '0;
        end else begin
            rd_pend <= step & ~we;
            if (start) begin
                cnt <= 2'd0;
            end else if (step) begin
                cnt <= cnt + 2'd1;
            end
            if (rd_pend) begin
                shift_q <= {shift_q[WORD_W-2*BYTE_W-1:0], mem_rdata};
            end
        end
    end

    // Store byte for the current count, most significant byte first.
    always_comb begin
        case (cnt)
            2'd0:    wbyte = wdata[31:24];
            2'd1:    wbyte = wdata[23:16];
            2'd2:    wbyte = wdata[15:8];
            default: wbyte = wdata[7:0];
        endcase
    end

    assign last = (cnt == 2'(BYTES_PER_WORD - 1));
    assign word = {shift_q, mem_rdata};

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one byte-wide single-port RAM between instruction fetch and
// load/store. Data wins contention unless fetch has been passed over
// STARVE_LIMIT times in a row.
module imem_dmem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [WORD_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int            SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_e              state;
    owner_e              owner;
    logic [ADDR_W-1:0]   base_q;
    logic                we_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [SW-1:0]       starve_cnt;

    logic                starve_hit;
    logic                grant_if;
    logic                grant_d;
    logic                start;
    logic [1:0]          cnt;
    logic                last;
    logic [BYTE_W-1:0]   wbyte;
    logic [WORD_W-1:0]   word;

    // Arbitration: data first, fetch once the starvation count is exhausted.
    always_comb begin
        starve_hit = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);
        grant_if   = if_req && (!d_req || starve_hit);
        grant_d    = d_req && !grant_if;
        start      = (state == IDLE) && (grant_if || grant_d);
    end

    arb_word_pack u_pack (
        .clock     (clock),
        .rst_n     (rst_n),
        .start     (start),
        .step      (state == XFER),
        .we        (we_q),
        .wdata     (wdata_q),
        .mem_rdata (mem_rdata),
        .cnt       (cnt),
        .last      (last),
        .wbyte     (wbyte),
        .word      (word)
    );

    // Transfer sequencer with registered acks and per-port read data.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            base_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            starve_cnt <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        owner   <= grant_d ? OWN_D : OWN_IF;
                        base_q  <= (grant_d ? d_addr : if_addr) & ~ADDR_W'(3);
                        we_q    <= grant_d & d_we;
                        wdata_q <= d_wdata;
                        if (grant_d && if_req) begin
                            if (starve_cnt != STARVE_MAX) begin
                                starve_cnt <= starve_cnt + SW'(1);
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (last) begin
                        if (we_q) begin
                            state  <= DONE;
                            d_ack  <= (owner == OWN_D);
                            if_ack <= (owner == OWN_IF);
                        end else begin
                            state <= CAPT;
                        end
                    end
                end
                CAPT: begin
                    state <= DONE;
                    if (owner == OWN_D) begin
                        d_rdata <= word;
                        d_ack   <= 1'b1;
                    end else begin
                        if_rdata <= word;
                        if_ack   <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes decoded from the sequencer; quiet outside XFER.
    always_comb begin
        busy      = (state != IDLE);
        mem_en    = (state == XFER);
        mem_we    = mem_en & we_q;
        mem_addr  = mem_en ? (base_q + ADDR_W'(cnt)) : '0;
        mem_wdata = mem_we ? wbyte : '0;
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed vector table, random single
// transactions against a byte-array reference, contention ordering and
// reset in the middle of a store.
module tb_imem_dmem_arbiter;

    localparam int LIM = 2;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [9:0]  if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [9:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] last_if;
    logic [31:0] last_d;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vt [7];

    imem_dmem_arbiter #(.ADDR_W(10), .STARVE_LIMIT(LIM)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Byte RAM: synchronous write, read data one cycle after the strobe.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [9:0] a);
        logic [9:0] b;
        b = a & ~10'h3;
        return {ref_mem[b], ref_mem[b + 10'd1], ref_mem[b + 10'd2], ref_mem[b + 10'd3]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preset(input logic [9:0] a, input logic [31:0] w);
        logic [31:0] s;
        for (int i = 0; i < 4; i++) begin
            s = w >> (8 * (3 - i));
            mem[a + 10'(i)]     = s[7:0];
            ref_mem[a + 10'(i)] = s[7:0];
        end
    endtask

    // One isolated transaction starting from an IDLE sample point.
    task automatic apply(input string nm, input bit is_d, input bit we, input logic [9:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat);
        logic [9:0]  base;
        logic [31:0] s;
        int          n;
        int          lat;
        base = addr & ~10'h3;
        chk({nm, "_idle"}, 32'(busy), 32'd0);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        n = 0;
        lat = -1;
        while (lat < 0 && n < 20) begin
            tick();
            n++;
            if (n <= 4) begin
                chk({nm, "_en"}, 32'(mem_en), 32'd1);
                chk({nm, "_addr"}, 32'(mem_addr), 32'(base + 10'(n - 1)));
                chk({nm, "_we"}, 32'(mem_we), 32'(we));
                if (we) begin
                    s = wd >> (8 * (4 - n));
                    chk({nm, "_wbyte"}, 32'(mem_wdata), 32'(s[7:0]));
                end
            end else begin
                chk({nm, "_en_off"}, 32'(mem_en), 32'd0);
            end
            if (is_d ? d_ack : if_ack) lat = n;
            chk({nm, "_other_ack"}, 32'(is_d ? if_ack : d_ack), 32'd0);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        if (!we) chk({nm, "_rdata"}, is_d ? d_rdata : if_rdata, exp_rd);
        if (is_d) chk({nm, "_if_hold"}, if_rdata, last_if);
        if (!is_d || we) chk({nm, "_d_hold"}, d_rdata, last_d);
        if (!we) begin
            if (is_d) last_d = exp_rd;
            else      last_if = exp_rd;
        end else begin
            for (int i = 0; i < 4; i++) begin
                s = wd >> (8 * (3 - i));
                ref_mem[base + 10'(i)] = s[7:0];
            end
        end
        tick();
        chk({nm, "_back_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          exp_order [6];
        int          got [$];
        int          sc;
        int          n;
        logic [31:0] prev_if;
        logic [31:0] exp_if;
        logic [31:0] exp_d;
        bit          rd_d;
        bit          rw;
        logic [9:0]  ra;
        logic [31:0] rwd;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        preset(10'h000, 32'h8C010004);
        preset(10'h3FC, 32'hA1B2C3D4);

        #3;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        last_if = 32'h0;
        last_d  = 32'h0;
        tick();
        rst_n = 1'b1;
        tick();

        vt[0] = '{1'b0, 1'b0, 10'h000, 32'h0,        32'h8C010004, 6};
        vt[1] = '{1'b1, 1'b1, 10'h020, 32'hDEADBEEF, 32'h0,        5};
        vt[2] = '{1'b1, 1'b0, 10'h020, 32'h0,        32'hDEADBEEF, 6};
        vt[3] = '{1'b1, 1'b0, 10'h3FE, 32'h0,        32'hA1B2C3D4, 6};
        vt[4] = '{1'b0, 1'b0, 10'h3FF, 32'h0,        32'hA1B2C3D4, 6};
        vt[5] = '{1'b1, 1'b1, 10'h041, 32'h55667788, 32'h0,        5};
        vt[6] = '{1'b1, 1'b0, 10'h042, 32'h0,        32'h55667788, 6};
        for (int i = 0; i < 7; i++) begin
            apply($sformatf("vec%0d", i), vt[i].is_d, vt[i].we, vt[i].addr,
                  vt[i].wd, vt[i].exp_rd, vt[i].exp_lat);
        end
        chk("mem20", 32'(mem[10'h020]), 32'hDE);
        chk("mem21", 32'(mem[10'h021]), 32'hAD);
        chk("mem22", 32'(mem[10'h022]), 32'hBE);
        chk("mem23", 32'(mem[10'h023]), 32'hEF);

        for (int k = 0; k < 40; k++) begin
            rd_d = 1'($urandom_range(0, 1));
            rw   = rd_d ? 1'($urandom_range(0, 1)) : 1'b0;
            ra   = 10'($urandom);
            rwd  = $urandom;
            apply($sformatf("rnd%0d", k), rd_d, rw, ra, rwd, rw ? 32'h0 : ref_word(ra), rw ? 5 : 6);
        end

        // Both ports requesting continuously: fetch gets every (LIM+1)-th grant.
        sc = 0;
        for (int g = 0; g < 6; g++) begin
            if (sc == LIM) begin
                exp_order[g] = 0;
                sc = 0;
            end else begin
                exp_order[g] = 1;
                sc = sc + 1;
            end
        end
        exp_if = ref_word(10'h3FC);
        exp_d  = ref_word(10'h020);
        if_req = 1'b1; if_addr = 10'h3FC;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 10'h020;
        prev_if = if_rdata;
        n = 0;
        while (got.size() < 6 && n < 200) begin
            tick();
            n++;
            if (if_ack) begin
                got.push_back(0);
                chk("cont_if_rdata", if_rdata, exp_if);
            end else begin
                chk("cont_if_hold", if_rdata, prev_if);
            end
            if (d_ack) begin
                got.push_back(1);
                chk("cont_d_rdata", d_rdata, exp_d);
            end
            prev_if = if_rdata;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("cont_grants", 32'(got.size()), 32'd6);
        for (int i = 0; i < got.size() && i < 6; i++) begin
            chk($sformatf("cont_order%0d", i), 32'(got[i]), 32'(exp_order[i]));
        end
        tick();
        tick();
        last_if = exp_if;
        last_d  = exp_d;

        // Reset after the second byte of a store has been written.
        preset(10'h040, 32'h000099AA);
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h040; d_wdata = 32'h11223344;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        d_req = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
        chk("mid_rst_mem40", 32'(mem[10'h040]), 32'h11);
        chk("mid_rst_mem41", 32'(mem[10'h041]), 32'h22);
        chk("mid_rst_mem42", 32'(mem[10'h042]), 32'h99);
        chk("mid_rst_mem43", 32'(mem[10'h043]), 32'hAA);
        chk("mid_rst_d_rdata", d_rdata, 32'h0);
        tick();
        chk("mid_rst_d_ack", 32'(d_ack), 32'd0);
        rst_n = 1'b1;
        ref_mem[10'h040] = 8'h11;
        ref_mem[10'h041] = 8'h22;
        last_if = 32'h0;
        last_d  = 32'h0;
        tick();
        chk("post_rst_d_ack", 32'(d_ack), 32'd0);
        apply("post_rst_load", 1'b1, 1'b0, 10'h040, 32'h0, 32'h112299AA, 6);
        apply("post_rst_fetch", 1'b0, 1'b0, 10'h001, 32'h0, 32'h8C010004, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port, byte-wide memory between the pipeline's instruction-fetch port (read-only) and its load/store port (read/write).
- Serialises each 32-bit word access into 4 byte accesses in big-endian order: byte at addr → word[31:24], addr+3 → word[7:0].
- Arbitrates between the two ports with data priority plus a fetch starvation guard.
- Sits between the pipelined CPU core and the shared instruction/data byte RAM.

Parameters:
- ADDR_W, 10: byte-address width; the memory holds 2^ADDR_W bytes.
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch waits; 0 means strict data priority.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  32  fetched word; valid from if_ack, held until next if_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  32  load word; valid from d_ack, held until next load d_ack.
- mem_en  out  1  memory byte access strobe.
- mem_we  out  1  byte write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; valid in the cycle after mem_en=1, mem_we=0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - mem_en, mem_we, if_ack, d_ack and busy are 0; mem_addr and mem_wdata are 0.
  - if_rdata and d_rdata are 0x00000000; starvation counter is 0.
- Reset mid-transaction: the transfer is abandoned. Bytes already written stay written; there is no rollback and no ack.
- States:
  - IDLE: arbitrate; no memory access.
  - XFER: issue bytes 0–3, one per cycle, under a 2-bit byte counter.
  - CAPT: loads only; capture the last byte.
  - DONE: pulse the owner's ack.
- Arbitration:
  - Requests are sampled only in IDLE.
  - Only d_req → grant data.
  - Only if_req → grant fetch.
  - Both → grant data, unless starve_cnt == STARVE_LIMIT and STARVE_LIMIT != 0; then grant fetch.
  - starve_cnt increments on each data grant made while if_req=1, saturating at STARVE_LIMIT.
  - starve_cnt clears on any fetch grant, and on any grant made while if_req=0.
- Grant actions:
  - Latch owner, base address with bits [1:0] forced to 00 (misaligned addresses are silently aligned), we (forced to 0 for fetch) and wdata.
  - Go to XFER with cnt=0.
- XFER:
  - mem_en=1, mem_addr = base+cnt, wrapping modulo 2^ADDR_W.
  - Stores: mem_we=1, mem_wdata = wdata byte cnt, MSB first.
  - Loads: each mem_rdata is shifted into a 32-bit assembly register on the cycle after its issue.
  - When cnt=3: store → DONE, load → CAPT.
- CAPT: mem_en=0; capture byte 3; → DONE.
- DONE:
  - Owner's ack=1 for exactly one cycle.
  - Load: the owner's rdata register is updated in the same edge that raises ack. The other port's rdata is untouched.
  - → IDLE.
- Latency, counted from the IDLE cycle with req sampled (cycle 0):
  - Store: mem_en in cycles 1–4, ack in cycle 5.
  - Load: mem_en in cycles 1–4, ack in cycle 6.
  - Minimum spacing between grants is 6 cycles for stores and 7 for loads; IDLE always lasts at least one cycle.
- Requester rules:
  - The requester holds req/addr/we/wdata stable until ack.
  - A req still high in the IDLE cycle after ack is a new request.
  - Request changes during a transfer are ignored.
- Stores to the address currently being fetched are not detected; ordering is the owner sequence only.

Decomposition:
- Package arb_pkg:
  - state enum {IDLE, XFER, CAPT, DONE}.
  - owner encoding {OWN_IF=0, OWN_D=1}.
  - WORD_W=32, BYTE_W=8, BYTES_PER_WORD=4.
- Sub-module arb_word_pack:
  - Holds the 2-bit byte counter, the 32→8 store byte select and the 8→32 big-endian load shift register.
  - Inputs: start, we, wdata, mem_rdata.
  - Outputs: cnt, last, wbyte, word.

Test Plan:
- Fetch only:
  - Stimulus: mem[0..3]=8C,01,00,04; if_req, if_addr=0.
  - Response: mem_addr 0,1,2,3 in cycles 1–4; if_ack in cycle 6; if_rdata=0x8C010004; d_ack never.
- Store then load:
  - Stimulus: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, then a load from 0x20.
  - Response: write bytes DE,AD,BE,EF to 0x20–0x23; d_ack in cycle 5; the load returns d_rdata=0xDEADBEEF with ack in cycle 6.
- Contention, STARVE_LIMIT=2:
  - Stimulus: if_req and d_req held high continuously.
  - Response: grant order D,D,IF,D,D,IF; if_rdata changes only on if_ack.
- Wrap and alignment, ADDR_W=10:
  - Stimulus: d_addr=0x3FE load.
  - Response: mem_addr 0x3FC..0x3FF; no wrap past 0x3FF.
  - Stimulus: if_addr=0x3FF.
  - Response: same aligned base 0x3FC.
- Reset mid-store:
  - Stimulus: rst_n low after byte 1 of a store of 0x11223344 to 0x40.
  - Response: mem[0x40]=11 and mem[0x41]=22; 0x42–0x43 unchanged; no d_ack; busy=0 asynchronously; the next request completes normally.
